mem_ctrl: RTL and testbench

- Byte-serial memory controller; sits between the pipeline and the single 8-bit RAM port.
- Arbitrates instruction fetch (IF stage) and load/store (MEM stage) requests onto one RAM port.
- Sequences each request into 1/2/4 byte accesses, little-endian.
- Returns a one-cycle done pulse with assembled data; MEM stage performs sign/zero extension and stall logic.

---
 rtl/mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial controller arbitrating IF fetches and MEM load/stores onto one 8-bit RAM port.
// Reads take len+2 cycles to done, writes len+1; requests are sampled only in IDLE.
`ifndef AluOpBus
`define AluOpBus 7:0
`endif

module mem_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter bit MEM_PRIORITY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  inst_done,
    output logic [31:0]           inst,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [`AluOpBus]      mem_aluop_i,
    input  logic [31:0]           rt_data_i,
    output logic                  load_store_mem_ctrl_done,
    output logic [31:0]           rdata,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]            mem_dout,
    output logic                  mem_wr,
    input  logic [7:0]            mem_din
);

    localparam logic [`AluOpBus] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [`AluOpBus] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [`AluOpBus] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [`AluOpBus] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [`AluOpBus] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [`AluOpBus] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [`AluOpBus] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [`AluOpBus] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [2:0]            cnt;
    logic [2:0]            len;
    logic                  owner_mem;
    logic                  is_wr;
    logic [ADDR_WIDTH-1:0] base;
    logic [31:0]           sdata;

    logic                  op_ls;
    logic                  op_wr;
    logic [2:0]            op_len;
    logic                  if_vld;
    logic                  grant_mem;
    logic                  flush_abort;
    logic [2:0]            nxt_cnt;
    logic [1:0]            lane;
    logic [ADDR_WIDTH-1:0] nxt_addr;

    always_comb begin
        op_ls  = 1'b1;
        op_wr  = 1'b0;
        op_len = 3'd4;
        case (mem_aluop_i)
            EXE_LB_OP, EXE_LBU_OP: op_len = 3'd1;
            EXE_LH_OP, EXE_LHU_OP: op_len = 3'd2;
            EXE_LW_OP:             op_len = 3'd4;
            EXE_SB_OP: begin op_wr = 1'b1; op_len = 3'd1; end
            EXE_SH_OP: begin op_wr = 1'b1; op_len = 3'd2; end
            EXE_SW_OP: begin op_wr = 1'b1; op_len = 3'd4; end
            default:               op_ls = 1'b0;
        endcase
    end

    assign if_vld      = if_req & ~if_flush;
    assign grant_mem   = op_ls & (MEM_PRIORITY | ~if_vld);
    assign flush_abort = (state == BUSY) & ~owner_mem & if_flush;
    assign nxt_cnt     = cnt + 3'd1;
    // At cnt=len the 2-bit wrap of len-1 still lands on the right lane (4 -> lane 3).
    assign lane        = cnt[1:0] - 2'd1;
    assign nxt_addr    = base + {{(ADDR_WIDTH-3){1'b0}}, nxt_cnt};

    assign inst_done                = (state == DONE) & ~owner_mem & ~if_flush;
    assign load_store_mem_ctrl_done = (state == DONE) & owner_mem;

    // RAM-side outputs are registered one step ahead so they are stable for the whole cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            len       <= 3'd0;
            owner_mem <= 1'b0;
            is_wr     <= 1'b0;
            base      <= '0;
            sdata     <= 32'd0;
            mem_a     <= '0;
            mem_dout  <= 8'd0;
            mem_wr    <= 1'b0;
            rdata     <= 32'd0;
            inst      <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    mem_wr <= 1'b0;
                    if (grant_mem || if_vld) begin
                        state     <= BUSY;
                        cnt       <= 3'd0;
                        owner_mem <= grant_mem;
                        base      <= grant_mem ? mem_addr_i : if_addr;
                        len       <= grant_mem ? op_len : 3'd4;
                        is_wr     <= grant_mem & op_wr;
                        sdata     <= rt_data_i;
                        mem_a     <= grant_mem ? mem_addr_i : if_addr;
                        mem_wr    <= grant_mem & op_wr;
                        mem_dout  <= rt_data_i[7:0];
                        if (grant_mem && !op_wr) begin
                            rdata <= 32'd0;
                        end
                    end
                end
                BUSY: begin
                    cnt <= nxt_cnt;
                    if (flush_abort) begin
                        state  <= IDLE;
                        mem_wr <= 1'b0;
                    end else if (is_wr) begin
                        if (nxt_cnt == len) begin
                            state  <= DONE;
                            mem_wr <= 1'b0;
                        end else begin
                            mem_a    <= nxt_addr;
                            mem_dout <= sdata[{nxt_cnt[1:0], 3'b000} +: 8];
                        end
                    end else begin
                        if (cnt != 3'd0) begin
                            if (owner_mem) begin
                                rdata[{lane, 3'b000} +: 8] <= mem_din;
                            end else begin
                                inst[{lane, 3'b000} +: 8] <= mem_din;
                            end
                        end
                        if (cnt == len) begin
                            state <= DONE;
                        end else if (nxt_cnt != len) begin
                            mem_a <= nxt_addr;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    mem_wr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a small byte RAM model answering one cycle after mem_a.
module tb_mem_ctrl;

    localparam logic [7:0] NOP    = 8'b0000_0000;
    localparam logic [7:0] LB_OP  = 8'b1110_0000;
    localparam logic [7:0] LW_OP  = 8'b1110_0011;
    localparam logic [7:0] LBU_OP = 8'b1110_0100;
    localparam logic [7:0] SH_OP  = 8'b1110_1001;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        inst_done;
    logic [31:0] inst;
    logic [31:0] mem_addr_i;
    logic [7:0]  mem_aluop_i;
    logic [31:0] rt_data_i;
    logic        ls_done;
    logic [31:0] rdata;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;

    logic [7:0]  ram [0:4095];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [7:0]  pl_dat;

    int checks;
    int errors;

    mem_ctrl #(.ADDR_WIDTH(32), .MEM_PRIORITY(1'b1)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .if_req                   (if_req),
        .if_addr                  (if_addr),
        .if_flush                 (if_flush),
        .inst_done                (inst_done),
        .inst                     (inst),
        .mem_addr_i               (mem_addr_i),
        .mem_aluop_i              (mem_aluop_i),
        .rt_data_i                (rt_data_i),
        .load_store_mem_ctrl_done (ls_done),
        .rdata                    (rdata),
        .mem_a                    (mem_a),
        .mem_dout                 (mem_dout),
        .mem_wr                   (mem_wr),
        .mem_din                  (mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_addr] <= pl_dat;
        end else if (mem_wr) begin
            ram[mem_a[11:0]] <= mem_dout;
        end
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_dat  = d;
        tick();
        pl_en   = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        if_req      = 1'b0;
        if_addr     = 32'd0;
        if_flush    = 1'b0;
        mem_addr_i  = 32'd0;
        mem_aluop_i = NOP;
        rt_data_i   = 32'd0;
        pl_en       = 1'b0;
        pl_addr     = 12'd0;
        pl_dat      = 8'd0;
        tick();

        preload(12'h100, 8'h11); preload(12'h101, 8'h22);
        preload(12'h102, 8'h33); preload(12'h103, 8'h44);
        preload(12'h200, 8'h01); preload(12'h201, 8'h02);
        preload(12'h202, 8'h03); preload(12'h203, 8'h04);
        preload(12'h204, 8'h05); preload(12'h205, 8'h06);
        preload(12'h206, 8'h07); preload(12'h207, 8'h08);
        preload(12'h300, 8'h80);

        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("reset_dones", {30'd0, inst_done, ls_done}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick();

        // LW at 0x100: addresses on cycles 1..4, done on cycle 6
        mem_aluop_i = LW_OP;
        mem_addr_i  = 32'h100;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) mem_aluop_i = NOP;
            if (c <= 4) begin
                chk("lw_mem_a", mem_a, 32'h100 + 32'(c - 1));
                chk("lw_mem_wr", {31'd0, mem_wr}, 32'd0);
            end
            chk("lw_done", {31'd0, ls_done}, {31'd0, c == 6});
            if (c == 6) chk("lw_rdata", rdata, 32'h4433_2211);
        end

        // SH across the 32-bit address wrap
        mem_aluop_i = SH_OP;
        mem_addr_i  = 32'hFFFF_FFFF;
        rt_data_i   = 32'hAABB_CCDD;
        tick();
        mem_aluop_i = NOP;
        chk("sh_c1_a", mem_a, 32'hFFFF_FFFF);
        chk("sh_c1_dout", {24'd0, mem_dout}, 32'hDD);
        chk("sh_c1_wr", {31'd0, mem_wr}, 32'd1);
        tick();
        chk("sh_c2_a", mem_a, 32'h0000_0000);
        chk("sh_c2_dout", {24'd0, mem_dout}, 32'hCC);
        chk("sh_c2_wr", {31'd0, mem_wr}, 32'd1);
        tick();
        chk("sh_c3_wr", {31'd0, mem_wr}, 32'd0);
        chk("sh_c3_done", {31'd0, ls_done}, 32'd1);
        tick();
        chk("sh_ram_fff", {24'd0, ram[12'hFFF]}, 32'hDD);
        chk("sh_ram_000", {24'd0, ram[12'h000]}, 32'hCC);

        // Reset asserted at BUSY cnt=2 of an LW
        mem_aluop_i = LW_OP;
        mem_addr_i  = 32'h100;
        tick();
        mem_aluop_i = NOP;
        tick();
        tick();
        chk("rst_pre_a", mem_a, 32'h102);
        rst = 1'b1;
        #1;
        chk("rst_mid_a", mem_a, 32'd0);
        chk("rst_mid_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_mid_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        chk("rst_mid_dones", {30'd0, inst_done, ls_done}, 32'd0);
        #2;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rst_after_dones", {30'd0, inst_done, ls_done}, 32'd0);
            chk("rst_after_a", mem_a, 32'd0);
        end

        // Simultaneous fetch and LBU: MEM wins, fetch starts in the IDLE after MEM's DONE
        if_req      = 1'b1;
        if_addr     = 32'h200;
        mem_aluop_i = LBU_OP;
        mem_addr_i  = 32'h300;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 1) begin
                mem_aluop_i = NOP;
                chk("arb_c1_a", mem_a, 32'h300);
            end
            chk("arb_ls_done", {31'd0, ls_done}, {31'd0, c == 3});
            chk("arb_inst_done", {31'd0, inst_done}, {31'd0, c == 10});
            if (c == 3) chk("arb_rdata", rdata, 32'h0000_0080);
            if (c == 5) chk("arb_c5_a", mem_a, 32'h200);
            if (c == 10) begin
                chk("arb_inst", inst, 32'h0403_0201);
                if_req = 1'b0;
            end
        end

        // LB arriving during a fetch waits for the fetch to finish
        if_req  = 1'b1;
        if_addr = 32'h200;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 2) begin
                mem_aluop_i = LB_OP;
                mem_addr_i  = 32'h300;
            end
            chk("np_inst_done", {31'd0, inst_done}, {31'd0, c == 6});
            chk("np_ls_done", {31'd0, ls_done}, {31'd0, c == 10});
            if (c == 6) begin
                chk("np_inst", inst, 32'h0403_0201);
                if_req = 1'b0;
            end
            if (c == 8) chk("np_c8_a", mem_a, 32'h300);
            if (c == 10) begin
                chk("np_rdata", rdata, 32'h0000_0080);
                mem_aluop_i = NOP;
            end
        end

        // Flush at BUSY cnt=2 aborts the fetch; a new fetch follows
        if_req  = 1'b1;
        if_addr = 32'h200;
        tick();
        tick();
        tick();
        chk("fl_c3_a", mem_a, 32'h202);
        if_flush = 1'b1;
        tick();
        chk("fl_c4_done", {31'd0, inst_done}, 32'd0);
        chk("fl_c4_a", mem_a, 32'h202);
        if_flush = 1'b0;
        if_addr  = 32'h204;
        for (int c = 5; c <= 11; c++) begin
            tick();
            if (c == 5) chk("fl_c5_a", mem_a, 32'h204);
            chk("fl_inst_done", {31'd0, inst_done}, {31'd0, c == 10});
            if (c == 10) begin
                chk("fl_inst", inst, 32'h0807_0605);
                if_req = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
